muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two read operands from the register file; produces a write-back request (data, destination, write enable) for the register file write port.
- One operation in flight at a time. Start/busy/done handshake with the pipeline control, which stalls while busy_o=1.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clock_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  request a new operation; accepted only when busy_o=0.
- funct3_i  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a_i  input  WIDTH  rs1 value (rd_data_1 of the register file).
- operand_b_i  input  WIDTH  rs2 value (rd_data_2 of the register file).
- rd_i  input  5  destination register index.
- busy_o  output  1  high from the cycle after acceptance until done_o drops.
- done_o  output  1  one-cycle pulse; result valid.
- result_o  output  WIDTH  operation result.
- wr_register_o  output  5  latched rd_i, to the register file write address.
- reg_write_o  output  1  write enable to the register file: done_o AND (latched rd != 0).

Behaviour:
- Reset: state IDLE; busy_o=0, done_o=0, reg_write_o=0, result_o=0, wr_register_o=0, counter=0. Reset overrides start_i in the same cycle.
- Reset mid-operation: the operation is abandoned and no write-back occurs.
- Acceptance: on an edge with state IDLE, start_i=1, reset_i=0, the unit latches funct3_i, both operands, and rd_i. Call that cycle N.
- start_i while busy_o=1 is ignored and has no side effects.
- Operand inputs are don't-care after acceptance.
- States:
  - IDLE to CALC on acceptance, or IDLE to DONE on acceptance when a special case applies (see below).
  - CALC to DONE after WIDTH iterations. The counter runs 0..WIDTH-1, one iteration per cycle.
  - DONE to IDLE unconditionally.
- Timing: the normal path asserts done_o in cycle N+WIDTH+1 (N+33 for the default WIDTH). A special case asserts done_o in cycle N+1.
- done_o and reg_write_o are high for exactly one cycle, while in DONE.
- busy_o is high throughout CALC and DONE.
- A new start_i is accepted the cycle after DONE, when busy_o=0.
- result_o and wr_register_o update when entering DONE and hold until the next DONE or reset.
- Signed handling:
  - Signed operands are converted to magnitudes; the core is unsigned; the result sign is fixed on entering DONE.
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU, DIVU, REMU: unsigned.
- Multiply: shift-add over a 2*WIDTH product.
  - MUL returns the low WIDTH bits.
  - MULH/MULHSU/MULHU return the high WIDTH bits of the correctly signed 2*WIDTH product.
- Divide: restoring shift-subtract, one quotient bit per cycle.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Special cases (one-cycle path, no CALC):
  - Divide by zero (b=0): DIV/DIVU give all ones (0xFFFFFFFF); REM/REMU give a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Multiply ops never take the special path.
- Destination x0: the result is computed and done_o pulses, but reg_write_o stays 0.

Test Plan:
- Reset, then MUL a=7, b=0xFFFFFFFD (-3), rd=5, start at cycle N -> done_o=1 only at N+33; result_o=0xFFFFFFEB; wr_register_o=5; reg_write_o=1 for one cycle.
- MULH a=b=0x80000000 -> result_o=0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. All with done_o at N+33.
- DIVU a=0x1234, b=0 -> done_o at N+1, result_o=0xFFFFFFFF. REMU same -> 0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at N+1. REM same -> 0.
- start_i held high with different operands throughout an operation -> first result unchanged. Second op accepted the cycle after done_o; back-to-back spacing is 34 cycles.
- Assert reset_i at N+10 of a MUL -> busy_o=0 next cycle, no done_o/reg_write_o pulse, result_o=0. MUL with rd=0 -> done_o=1, reg_write_o=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Pipeline-side handshake and register-file signals of the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       funct3_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic [4:0]       rd_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [4:0]       wr_register_o;
  logic             reg_write_o;

  // Pipeline control / register file side
  modport master (
    output start_i, funct3_i, operand_a_i, operand_b_i, rd_i,
    input  busy_o, done_o, result_o, wr_register_o, reg_write_o
  );

  // Execution unit side
  modport slave (
    input  start_i, funct3_i, operand_a_i, operand_b_i, rd_i,
    output busy_o, done_o, result_o, wr_register_o, reg_write_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fixed up at the end.
//
// state | meaning
// IDLE  | waiting for start_i; special divide cases resolve directly to DONE
// CALC  | WIDTH iterations of the unsigned multiply or divide core
// DONE  | result valid for one cycle, write-back pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clock_i,
  input logic           reset_i,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;
  logic [4:0]       rd_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       wr_reg_q;

  logic [2:0]       f3;
  logic [WIDTH-1:0] a_in, b_in;
  logic             a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_result;
  logic             last_iter;

  logic [WIDTH:0]     mul_addend, mul_sum;
  logic [WIDTH:0]     div_shifted;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   next_hi, next_lo;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, calc_result;

  assign f3   = bus.funct3_i;
  assign a_in = bus.operand_a_i;
  assign b_in = bus.operand_b_i;

  // Operand sign decode, magnitudes and one-cycle divide special cases
  always_comb begin
    a_signed = !(f3 == 3'b011 || f3 == 3'b101 || f3 == 3'b111);
    b_signed = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
    a_neg    = a_signed && a_in[WIDTH-1];
    b_neg    = b_signed && b_in[WIDTH-1];
    a_mag    = a_neg ? -a_in : a_in;
    b_mag    = b_neg ? -b_in : b_in;
    // Remainder follows the dividend; everything else is the XOR of signs
    neg_in   = (f3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    div_zero = f3[2] && (b_in == '0);
    div_ovf  = f3[2] && !f3[0] && (a_in == {1'b1, {(WIDTH-1){1'b0}}}) && (b_in == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_result = f3[1] ? a_in : '1;
    else
      special_result = f3[1] ? '0 : a_in;
  end

  // One iteration of the shared multiply/divide core plus final sign fix-up
  always_comb begin
    mul_addend  = lo_q[0] ? {1'b0, opb_q} : '0;
    mul_sum     = {1'b0, hi_q} + mul_addend;
    div_shifted = {hi_q, lo_q[WIDTH-1]};
    div_ge      = div_shifted >= {1'b0, opb_q};
    div_sub     = div_shifted[WIDTH-1:0] - opb_q;
    if (op_q[2]) begin
      next_hi = div_ge ? div_sub : div_shifted[WIDTH-1:0];
      next_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod   = {next_hi, next_lo};
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -next_lo : next_lo;
    rem_s  = neg_q ? -next_hi : next_hi;
    if (op_q[2])
      calc_result = op_q[1] ? rem_s : quot_s;
    else if (op_q == 3'b000)
      calc_result = prod_s[WIDTH-1:0];
    else
      calc_result = prod_s[2*WIDTH-1:WIDTH];
  end

  assign last_iter = (count_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d         = state_q;
    bus.busy_o      = 1'b0;
    bus.done_o      = 1'b0;
    bus.reg_write_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = special ? DONE : CALC;
      end
      CALC: begin
        bus.busy_o = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        bus.busy_o      = 1'b1;
        bus.done_o      = 1'b1;
        bus.reg_write_o = (wr_reg_q != 5'd0);
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result/destination latching
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      result_q <= '0;
      wr_reg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            op_q    <= f3;
            neg_q   <= neg_in;
            hi_q    <= '0;
            lo_q    <= a_mag;
            opb_q   <= b_mag;
            rd_q    <= bus.rd_i;
            count_q <= '0;
            if (special) begin
              result_q <= special_result;
              wr_reg_q <= bus.rd_i;
            end
          end
        end
        CALC: begin
          hi_q    <= next_hi;
          lo_q    <= next_lo;
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            result_q <= calc_result;
            wr_reg_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o      = result_q;
  assign bus.wr_register_o = wr_reg_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations are queued at acceptance and
// compared (value, destination, write enable, latency) when done_o pulses.
module tb_muldiv_unit;

  logic clock_i = 1'b0;
  logic reset_i;
  int   cyc = 0;

  always #5 clock_i = ~clock_i;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_done = 1'b0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0]        u;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    u = '0;
    case (f)
      3'b000: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[31:0]; end
      3'b001: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'b010: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});       return p[63:32]; end
      3'b011: begin u = {32'b0, a} * {32'b0, b};                                return u[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        return $signed(a) / $signed(b);
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 0;
    return 32;
  endfunction

  // Scoreboard side: compare every done_o pulse against the oldest expectation
  always @(negedge clock_i) begin
    if (bus.done_o) begin
      check("done_width", prev_done, 1'b0);
      if (sb.size() == 0) begin
        check("spurious_done", bus.done_o, 1'b0);
      end else begin
        got = sb.pop_front();
        check("result", bus.result_o, got.result);
        check("wr_register", bus.wr_register_o, got.rd);
        check("reg_write", bus.reg_write_o, got.rd != 5'd0);
        check("busy_at_done", bus.busy_o, 1'b1);
        check("done_cycle", cyc, got.done_cyc);
      end
    end else begin
      if (bus.reg_write_o) check("reg_write_no_done", bus.reg_write_o, 1'b0);
    end
    prev_done = bus.done_o;
  end

  task automatic wait_idle();
    int t = 0;
    while (bus.busy_o && t < 100) begin
      @(negedge clock_i);
      t++;
    end
    if (bus.busy_o) check("idle_timeout", bus.busy_o, 1'b0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.done_o && t < 40) begin
      @(negedge clock_i);
      t++;
    end
    if (!bus.done_o) check("done_timeout", bus.done_o, 1'b1);
  endtask

  // Drives one request from a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input bit expect_done,
                       output int acc_cyc);
    wait_idle();
    bus.start_i     = 1'b1;
    bus.funct3_i    = f;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    bus.rd_i        = rd;
    @(posedge clock_i);
    #1;
    acc_cyc = cyc;
    if (expect_done) sb.push_back('{exp_res, rd, cyc + latency(f, a, b)});
    @(negedge clock_i);
    bus.start_i     = 1'b0;
    bus.operand_a_i = $urandom;
    bus.operand_b_i = $urandom;
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp_res);
    int acc;
    issue(f, a, b, rd, exp_res, 1'b1, acc);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    // Reset with start_i asserted: reset must win
    reset_i         = 1'b1;
    bus.start_i     = 1'b1;
    bus.funct3_i    = 3'b000;
    bus.operand_a_i = 32'd3;
    bus.operand_b_i = 32'd4;
    bus.rd_i        = 5'd1;
    repeat (3) @(posedge clock_i);
    #1;
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_reg_write", bus.reg_write_o, 1'b0);
    check("rst_result", bus.result_o, 32'h0);
    check("rst_wr_register", bus.wr_register_o, 5'd0);
    @(negedge clock_i);
    reset_i     = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clock_i);

    // Multiplies
    run(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
    run(3'b010, 32'hFFFF_FFFF, 32'd2,        5'd8,  32'hFFFF_FFFF);
    // Divides
    run(3'b100, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD);
    run(3'b110, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF);
    run(3'b101, 32'd100,       32'd7,        5'd11, 32'd14);
    run(3'b111, 32'd100,       32'd7,        5'd12, 32'd2);
    // One-cycle special cases
    run(3'b101, 32'h1234,      32'h0,        5'd13, 32'hFFFF_FFFF);
    run(3'b111, 32'h1234,      32'h0,        5'd14, 32'h1234);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0);

    // start_i held through the operation with new operands: second op
    // accepted only once idle, 34 cycles after the first
    wait_idle();
    bus.start_i     = 1'b1;
    bus.funct3_i    = 3'b000;
    bus.operand_a_i = 32'd1000;
    bus.operand_b_i = 32'd3;
    bus.rd_i        = 5'd20;
    @(posedge clock_i);
    #1;
    acc = cyc;
    sb.push_back('{32'd3000, 5'd20, acc + 32});
    sb.push_back('{32'd14, 5'd21, acc + 34 + 32});
    @(negedge clock_i);
    bus.funct3_i    = 3'b101;
    bus.operand_a_i = 32'd100;
    bus.operand_b_i = 32'd7;
    bus.rd_i        = 5'd21;
    wait_done();
    @(posedge clock_i);
    @(posedge clock_i);
    @(negedge clock_i);
    bus.start_i = 1'b0;
    wait_done();

    // Destination x0: done pulses but no register write
    run(3'b000, 32'd12, 32'd12, 5'd0, 32'd144);

    // Reset ten cycles into a MUL abandons it without write-back
    issue(3'b000, 32'd5, 32'd6, 5'd3, 32'd30, 1'b0, acc);
    while (cyc < acc + 9) @(negedge clock_i);
    reset_i = 1'b1;
    @(posedge clock_i);
    #1;
    check("midrst_busy", bus.busy_o, 1'b0);
    check("midrst_done", bus.done_o, 1'b0);
    check("midrst_reg_write", bus.reg_write_o, 1'b0);
    check("midrst_result", bus.result_o, 32'h0);
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (40) @(negedge clock_i);
    check("midrst_still_idle", bus.busy_o, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run(rf, ra, rb, 5'($urandom_range(0, 31)), model(rf, ra, rb));
    end

    repeat (5) @(negedge clock_i);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
